ps2_scancode_decoder: RTL

- Sits directly downstream of the PS/2 keyboard receiver.
- Consumes the receiver's byte-ready flag and 8-bit scan code (Set 2), then pulses the receiver's clear input to acknowledge each byte.
- Tracks the make/break (0xF0) and extended (0xE0) prefixes, plus Shift and Caps Lock state.
- Translates make codes to ASCII and buffers the characters in a small FIFO, which the CPU/peripheral bus reads through a read strobe.

---
 rtl/ps2_scancode_decoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scan-code decoder: synchronizes the receiver handshake, tracks
// break/extended prefixes and Shift/Caps state, translates makes to ASCII
// and buffers the characters in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_rda,
  input  logic [7:0] scan_code,
  output logic       kbd_clear,
  output logic       char_avail,
  output logic [7:0] char_data,
  input  logic       char_rd,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       shift_state,
  output logic       caps_state
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  logic               rda_meta_q, rda_sync_q, rda_prev_q, rda_edge;
  logic [7:0]         code_q;
  logic               dec_vld_q;
  state_t             state_q, state_d;
  logic               shl_q, shl_d, shr_q, shr_d, caps_q, caps_d;
  logic               is_make, is_ext, hit, is_let, push;
  logic [7:0]         ch;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ovf_q, full, empty, pop, wr_en, ovf_set;

  assign rda_edge = rda_sync_q & ~rda_prev_q;

  // Two-flop synchronizer, edge detector, and capture of the scan byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rda_meta_q <= 1'b0;
      rda_sync_q <= 1'b0;
      rda_prev_q <= 1'b0;
      code_q     <= 8'h00;
      dec_vld_q  <= 1'b0;
    end else begin
      rda_meta_q <= scan_rda;
      rda_sync_q <= rda_meta_q;
      rda_prev_q <= rda_sync_q;
      if (rda_edge) code_q <= scan_code;
      dec_vld_q  <= rda_edge;
    end
  end

  // Prefix FSM and modifier registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      caps_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      caps_q  <= caps_d;
    end
  end

  // Prefix tracking and modifier updates for the byte captured last cycle.
  always_comb begin
    state_d = state_q;
    shl_d   = shl_q;
    shr_d   = shr_q;
    caps_d  = caps_q;
    is_make = 1'b0;
    is_ext  = 1'b0;
    if (dec_vld_q) begin
      case (state_q)
        IDLE: begin
          if (code_q == 8'hE0)      state_d = EXT;
          else if (code_q == 8'hF0) state_d = BRK;
          else                      is_make = 1'b1;
        end
        EXT: begin
          if (code_q == 8'hF0) state_d = EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          if (code_q == 8'h12) shl_d = 1'b0;
          if (code_q == 8'h59) shr_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Modifiers belong to the normal set only.
    if (is_make && !is_ext) begin
      if (code_q == 8'h12) shl_d  = 1'b1;
      if (code_q == 8'h59) shr_d  = 1'b1;
      if (code_q == 8'h58) caps_d = ~caps_q;
    end
  end

  // Scan code to ASCII; letters are produced lowercase and shifted after.
  always_comb begin
    hit    = 1'b1;
    is_let = 1'b1;
    ch     = 8'h00;
    case (code_q)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
      8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
      8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
      8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
      8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
      8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
      8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      default: begin
        is_let = 1'b0;
        case (code_q)
          8'h45: ch = shift_state ? 8'h29 : 8'h30;
          8'h16: ch = shift_state ? 8'h21 : 8'h31;
          8'h1E: ch = shift_state ? 8'h40 : 8'h32;
          8'h26: ch = shift_state ? 8'h23 : 8'h33;
          8'h25: ch = shift_state ? 8'h24 : 8'h34;
          8'h2E: ch = shift_state ? 8'h25 : 8'h35;
          8'h36: ch = shift_state ? 8'h5E : 8'h36;
          8'h3D: ch = shift_state ? 8'h26 : 8'h37;
          8'h3E: ch = shift_state ? 8'h2A : 8'h38;
          8'h46: ch = shift_state ? 8'h28 : 8'h39;
          8'h29: ch = 8'h20;
          8'h5A: ch = 8'h0D;
          8'h66: ch = 8'h08;
          8'h76: ch = 8'h1B;
          default: hit = 1'b0;
        endcase
      end
    endcase
    if (is_let && (shift_state ^ caps_q)) ch = ch - 8'h20;
  end

  // Only Enter survives as an extended make.
  assign push    = is_make && hit && (!is_ext || code_q == 8'h5A);
  assign full    = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = char_rd && !empty;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ch;
  end

  // FIFO pointers, occupancy and sticky overflow (a set beats a clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (wr_en && !pop)      cnt_q <= cnt_q + (FIFO_AW+1)'(1);
      else if (!wr_en && pop) cnt_q <= cnt_q - (FIFO_AW+1)'(1);
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign kbd_clear   = rda_edge && !rst;
  assign char_avail  = !empty;
  assign char_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overflow    = ovf_q;
  assign shift_state = shl_q | shr_q;
  assign caps_state  = caps_q;

endmodule
